// File: rtl/sram_a_ctrl.sv
// sram_a_ctrl: synchronous initiator for the asynchronous SRAM_A port.
// Accepts single-word read/write requests on a valid/ready handshake. Each
// request is driven onto the SRAM pins in three phases:
//   SETUP  (1 cycle)    address and data settle, En=1, We=0
//   ACCESS (WAIT cycles) We follows the request type
//   HOLD   (1 cycle)    address and data held, We=0, response strobe
// Read data is captured on the edge that leaves ACCESS.
// Optional build feature: define SRAM_A_CTRL_CLEAR_EN to make the controller
// zero the whole memory after reset, before it accepts any request.
module sram_a_ctrl #(
    parameter int AW   = 8,
    parameter int DW   = 8,
    parameter int WAIT = 1     // ACCESS length in cycles, 1..15
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    // request side
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [AW-1:0] req_dir_i,
    input  logic [DW-1:0] req_dato_i,
    // response side
    output logic          rsp_valid_o,
    output logic [DW-1:0] rsp_dato_o,
    output logic          busy_o,
    // SRAM pins
    output logic [AW-1:0] dir_o,
    output logic [DW-1:0] dato_e_o,
    output logic          we_o,
    output logic          en_o,
    input  logic [DW-1:0] dato_s_i
);

    // The wait counter is loaded with WAIT-1 and counts down to 0, so four
    // bits cover the full legal range of WAIT.
    localparam logic [3:0] WAIT_M1 = 4'(WAIT - 1);

`ifdef SRAM_A_CTRL_CLEAR_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD,
        S_CLEAR
    } state_e;
    localparam state_e RST_STATE = S_CLEAR;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD
    } state_e;
    localparam state_e RST_STATE = S_IDLE;
`endif

    state_e        state_q;
    logic [3:0]    cnt_q;        // ACCESS cycles remaining after this one
    logic          wlat_q;       // latched request type, 1 = write
    logic [AW-1:0] dir_q;
    logic [DW-1:0] dato_e_q;
    logic          we_q;
    logic          en_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_dato_q;
    logic          sweep;        // high while the power-up clear is running

`ifdef SRAM_A_CTRL_CLEAR_EN
    logic [AW-1:0] clr_addr_q;   // next address the clear sweep writes
    logic          sweep_q;
    assign sweep = sweep_q;
`else
    assign sweep = 1'b0;
`endif

    // Control state, SRAM pin registers and response registers in one place;
    // every pin is registered, so each phase's pin values are set on the edge
    // that enters that phase.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            wlat_q      <= 1'b0;
            dir_q       <= '0;
            dato_e_q    <= '0;
            we_q        <= 1'b0;
            en_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dato_q  <= '0;
`ifdef SRAM_A_CTRL_CLEAR_EN
            clr_addr_q  <= '0;
            sweep_q     <= 1'b1;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    // req_ready is high throughout IDLE, so valid alone accepts
                    if (req_valid_i) begin
                        state_q  <= S_SETUP;
                        wlat_q   <= req_we_i;
                        dir_q    <= req_dir_i;
                        dato_e_q <= req_dato_i;
                        en_q     <= 1'b1;
                        we_q     <= 1'b0;
                    end
                end
                S_SETUP: begin
                    state_q <= S_ACCESS;
                    we_q    <= wlat_q;
                    cnt_q   <= WAIT_M1;
                end
                S_ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= S_HOLD;
                        we_q        <= 1'b0;
                        // clear-sweep writes are internal and produce no response
                        rsp_valid_q <= ~sweep;
                        if (!wlat_q)
                            rsp_dato_q <= dato_s_i;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_HOLD: begin
                    en_q        <= 1'b0;
                    rsp_valid_q <= 1'b0;
`ifdef SRAM_A_CTRL_CLEAR_EN
                    if (sweep_q) begin
                        // stop at the top address rather than wrapping
                        if (clr_addr_q == {AW{1'b1}}) begin
                            sweep_q <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            clr_addr_q <= clr_addr_q + 1'b1;
                            state_q    <= S_CLEAR;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
`ifdef SRAM_A_CTRL_CLEAR_EN
                S_CLEAR: begin
                    // plays the role of IDLE for the sweep: launch a write of 0
                    state_q  <= S_SETUP;
                    wlat_q   <= 1'b1;
                    dir_q    <= clr_addr_q;
                    dato_e_q <= '0;
                    en_q     <= 1'b1;
                    we_q     <= 1'b0;
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dato_o  = rsp_dato_q;
    assign dir_o       = dir_q;
    assign dato_e_o    = dato_e_q;
    assign we_o        = we_q;
    assign en_o        = en_q;

endmodule

// File: tb/tb_sram_a_ctrl.sv
// Directed bench for sram_a_ctrl (default build). Two instances run side by
// side: index 0 with WAIT=1, index 1 with WAIT=3, each with its own SRAM_A
// behavioural model.
module tb_sram_a_ctrl;

    logic       clk;
    logic       rst_n     [2];
    logic       req_valid [2];
    logic       req_ready [2];
    logic       req_we    [2];
    logic [7:0] req_dir   [2];
    logic [7:0] req_dato  [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_dato  [2];
    logic       busy      [2];
    logic [7:0] dir       [2];
    logic [7:0] dato_e    [2];
    logic       we        [2];
    logic       en        [2];
    logic [7:0] dato_s    [2];

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int acc      [2];
    int prev_acc [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sram_a_ctrl #(.AW(8), .DW(8), .WAIT(1)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_we_i(req_we[0]), .req_dir_i(req_dir[0]), .req_dato_i(req_dato[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_dato_o(rsp_dato[0]), .busy_o(busy[0]),
        .dir_o(dir[0]), .dato_e_o(dato_e[0]), .we_o(we[0]), .en_o(en[0]),
        .dato_s_i(dato_s[0])
    );

    sram_a_ctrl #(.AW(8), .DW(8), .WAIT(3)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_we_i(req_we[1]), .req_dir_i(req_dir[1]), .req_dato_i(req_dato[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_dato_o(rsp_dato[1]), .busy_o(busy[1]),
        .dir_o(dir[1]), .dato_e_o(dato_e[1]), .we_o(we[1]), .en_o(en[1]),
        .dato_s_i(dato_s[1])
    );

    // SRAM_A models: combinational read, write while enabled and write-enabled
    assign dato_s[0] = mem0[dir[0]];
    assign dato_s[1] = mem1[dir[1]];
    always @(posedge clk) begin
        if (en[0] && we[0]) mem0[dir[0]] <= dato_e[0];
        if (en[1] && we[1]) mem1[dir[1]] <= dato_e[1];
    end

    // cycle counter and acceptance-edge recorder
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (req_valid[k] && req_ready[k]) begin
                prev_acc[k] = acc[k];
                acc[k]      = cyc;
            end
        cyc = cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on instance k, starting in an IDLE cycle. req_valid is
    // left high so back-to-back calls model a continuously held request.
    task automatic txn(input int k, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input logic chk_rd, input logic [7:0] exp_rd,
                       input logic chk_gap);
        int wv;
        wv = (k == 0) ? 1 : 3;
        req_we[k]    = w;
        req_dir[k]   = a;
        req_dato[k]  = d;
        req_valid[k] = 1'b1;
        tick();
        if (chk_gap) check("accept_gap", 32'(acc[k] - prev_acc[k]), 32'(wv + 3));
        for (int c = 1; c <= wv + 3; c++) begin
            check("en",        32'(en[k]),        32'(c <= wv + 2));
            check("we",        32'(we[k]),        32'(w && c >= 2 && c <= wv + 1));
            check("rsp_valid", 32'(rsp_valid[k]), 32'(c == wv + 2));
            check("req_ready", 32'(req_ready[k]), 32'(c == wv + 3));
            check("busy",      32'(busy[k]),      32'(c != wv + 3));
            check("dir",       32'(dir[k]),       32'(a));
            if (w) check("dato_e", 32'(dato_e[k]), 32'(d));
            if (chk_rd && c == wv + 2) check("rsp_dato", 32'(rsp_dato[k]), 32'(exp_rd));
            if (c < wv + 3) tick();
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0;
            req_dir[k] = 8'd0; req_dato[k] = 8'd0; acc[k] = 0; prev_acc[k] = 0;
        end
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'hxx;
            mem1[i] = 8'hxx;
        end

        // reset held for three cycles, then released
        repeat (3) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("rst_dir",       32'(dir[k]),       32'd0);
            check("rst_dato_e",    32'(dato_e[k]),    32'd0);
            check("rst_we",        32'(we[k]),        32'd0);
            check("rst_en",        32'(en[k]),        32'd0);
            check("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            check("rst_rsp_dato",  32'(rsp_dato[k]),  32'd0);
            check("rst_req_ready", 32'(req_ready[k]), 32'd1);
            check("rst_busy",      32'(busy[k]),      32'd0);
        end

        // single write then read-back, WAIT=1
        txn(0, 1'b1, 8'd0, 8'd200, 1'b0, 8'd0, 1'b0);
        req_valid[0] = 1'b0;
        tick();
        txn(0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd200, 1'b0);
        req_valid[0] = 1'b0;
        tick();
        check("idle_keeps_rsp_dato", 32'(rsp_dato[0]), 32'd200);

        // held-request sweeps: writes then reads, on both WAIT settings
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 12; i++)
                txn(k, 1'b1, 8'(i), 8'(200 + i), 1'b0, 8'd0, i > 0);
            for (int i = 0; i < 12; i++)
                txn(k, 1'b0, 8'(i), 8'd0, 1'b1, 8'(200 + i), 1'b1);
            req_valid[k] = 1'b0;
            tick();
            // a write must leave the captured read data alone
            txn(k, 1'b1, 8'd40, 8'd77, 1'b1, 8'd211, 1'b0);
            req_valid[k] = 1'b0;
            tick();
        end

        // reset asserted mid-ACCESS of a write on the WAIT=1 instance
        req_we[0] = 1'b1; req_dir[0] = 8'd5; req_dato[0] = 8'h55; req_valid[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        tick();
        check("pre_rst_we", 32'(we[0]), 32'd1);
        #2;
        rst_n[0] = 1'b0;
        #1;
        check("async_we",     32'(we[0]),        32'd0);
        check("async_en",     32'(en[0]),        32'd0);
        check("async_dir",    32'(dir[0]),       32'd0);
        check("async_dato_e", 32'(dato_e[0]),    32'd0);
        check("async_rdato",  32'(rsp_dato[0]),  32'd0);
        tick();
        check("rst_no_rsp",   32'(rsp_valid[0]), 32'd0);
        rst_n[0] = 1'b1;
        check("post_rst_ready", 32'(req_ready[0]), 32'd1);
        check("post_rst_busy",  32'(busy[0]),      32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("post_rst_no_rsp", 32'(rsp_valid[0]), 32'd0);
            check("post_rst_idle",   32'(en[0]),        32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
